circ_fifo: RTL

CIRC_FIFO -- requirements
Module: circ_fifo

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/circ_fifo_if.sv | 37 +++
 rtl/fifo_mem.sv | 30 +++
 rtl/circ_fifo.sv | 109 ++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the circular FIFO slice.
// Holds the default geometry and the packed status bundle.
package fifo_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_WIDTH = 8;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int ptr_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/circ_fifo_if.sv
// Push/pop handshake and status bundle of the circular FIFO.
// master = the user driving push/pop, slave = the FIFO itself.
interface circ_fifo_if
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEFAULT_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_DEPTH
);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);

  logic                  wr_en;
  logic [FIFO_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic                  clr_err;
  logic [FIFO_WIDTH-1:0] rd_data;
  logic                  rd_vld;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_W:0]       count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_vld, fifo_empty, fifo_full, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_vld, fifo_empty, fifo_full, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: one write port, one registered read port, no reset.
// A same-edge read and write of one address returns the old contents.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int ADDR_W = $clog2(DEFAULT_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [WIDTH-1:0]  q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
    if (re) begin
      q <= mem[ra];
    end
  end

endmodule

// File: rtl/circ_fifo.sv
// Circular-buffer FIFO: wrap-bit pointers, occupancy/threshold flags,
// sticky overflow/underflow, registered read data with a valid pulse.
module circ_fifo
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH    = DEFAULT_DEPTH,
  parameter int FIFO_WIDTH    = DEFAULT_WIDTH,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic        clk,
  input  logic        rst,
  circ_fifo_if.slave  bus
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [ADDR_W:0] PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_W:0] DEPTH_L  = PTR_W'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] AFULL_L  = PTR_W'(AFULL_THRESH);
  localparam logic [ADDR_W:0] AEMPTY_L = PTR_W'(AEMPTY_THRESH);

  logic [ADDR_W:0]       wr_ptr_reg;
  logic [ADDR_W:0]       rd_ptr_reg;
  logic [ADDR_W:0]       count_w;
  logic                  rd_vld_reg;
  logic                  rd_seen_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  pop_acc;
  logic                  push_acc;
  logic [FIFO_WIDTH-1:0] mem_q;
  fifo_status_t          status;

  // Pointers carry a wrap bit, so occupancy is a plain modular difference.
  assign count_w = wr_ptr_reg - rd_ptr_reg;

  always_comb begin
    status              = '0;
    status.empty        = (count_w == '0);
    status.full         = (count_w == DEPTH_L);
    status.almost_empty = (count_w <= AEMPTY_L);
    status.almost_full  = (count_w >= AFULL_L);
    status.overflow     = overflow_reg;
    status.underflow    = underflow_reg;
  end

  assign pop_acc  = bus.rd_en && !status.empty;
  assign push_acc = bus.wr_en && (!status.full || pop_acc);

  fifo_mem #(
    .DEPTH  (FIFO_DEPTH),
    .WIDTH  (FIFO_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk (clk),
    .we  (push_acc),
    .wa  (wr_ptr_reg[ADDR_W-1:0]),
    .wd  (bus.wr_data),
    .re  (pop_acc),
    .ra  (rd_ptr_reg[ADDR_W-1:0]),
    .q   (mem_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      rd_vld_reg    <= 1'b0;
      rd_seen_reg   <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop_acc) begin
        rd_ptr_reg  <= rd_ptr_reg + PTR_ONE;
        rd_seen_reg <= 1'b1;
      end
      rd_vld_reg <= pop_acc;

      // A new error event takes priority over a clear in the same cycle.
      if (bus.wr_en && !push_acc) begin
        overflow_reg <= 1'b1;
      end else if (bus.clr_err) begin
        overflow_reg <= 1'b0;
      end
      if (bus.rd_en && !pop_acc) begin
        underflow_reg <= 1'b1;
      end else if (bus.clr_err) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  // The storage has no reset; rd_data reads as zero until the first pop
  // after reset so the output register still shows a clean reset value.
  assign bus.rd_data      = rd_seen_reg ? mem_q : '0;
  assign bus.rd_vld       = rd_vld_reg;
  assign bus.count        = count_w;
  assign bus.fifo_empty   = status.empty;
  assign bus.fifo_full    = status.full;
  assign bus.almost_empty = status.almost_empty;
  assign bus.almost_full  = status.almost_full;
  assign bus.overflow     = status.overflow;
  assign bus.underflow    = status.underflow;

endmodule
